scarv_cop_mp_wb: RTL and testbench

Multi-precision writeback sequencer sitting directly downstream of the coprocessor multi-precision ALU. It captures the one or two 32-bit result words the ALU emits per instruction and steers each to the correct CPR destination: a single register, or the even/odd halves of a register pair. Words are buffered in a 2-entry FIFO and drained into the shared CPR write port under an arbiter grant. The block reports when the final word of an instruction has committed.

---
 rtl/scarv_cop_mp_wb_if.sv | 39 +++
 rtl/scarv_cop_mp_wb.sv | 128 ++++++++++++
 tb/tb_scarv_cop_mp_wb.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scarv_cop_mp_wb_if.sv
// rtl/scarv_cop_mp_wb_if.sv - ALU-result, CPR write-port and status signals of the writeback sequencer
//
// Signals:
//   malu_ivalid, malu_idone, malu_cpr_rd_ben[3:0], malu_cpr_rd_wdata[31:0] : ALU result beats
//   id_crd[3:0], id_crdm[2:0]                       : destination register / register-pair index
//   cpr_wgnt                                        : CPR write port grant
//   cpr_wen, cpr_waddr[3:0], cpr_wben[3:0], cpr_wdata[31:0] : CPR write request
//   wb_busy, wb_done, wb_overflow                   : sequencer status
// Modports: slave = the sequencer, master = its environment.
interface scarv_cop_mp_wb_if;
    logic        malu_ivalid;
    logic        malu_idone;
    logic [3:0]  malu_cpr_rd_ben;
    logic [31:0] malu_cpr_rd_wdata;
    logic [3:0]  id_crd;
    logic [2:0]  id_crdm;
    logic        cpr_wgnt;
    logic        cpr_wen;
    logic [3:0]  cpr_waddr;
    logic [3:0]  cpr_wben;
    logic [31:0] cpr_wdata;
    logic        wb_busy;
    logic        wb_done;
    logic        wb_overflow;

    modport slave (
        input  malu_ivalid, malu_idone, malu_cpr_rd_ben, malu_cpr_rd_wdata,
        input  id_crd, id_crdm, cpr_wgnt,
        output cpr_wen, cpr_waddr, cpr_wben, cpr_wdata,
        output wb_busy, wb_done, wb_overflow
    );

    modport master (
        output malu_ivalid, malu_idone, malu_cpr_rd_ben, malu_cpr_rd_wdata,
        output id_crd, id_crdm, cpr_wgnt,
        input  cpr_wen, cpr_waddr, cpr_wben, cpr_wdata,
        input  wb_busy, wb_done, wb_overflow
    );
endinterface

// File: rtl/scarv_cop_mp_wb.sv
// rtl/scarv_cop_mp_wb.sv - multi-precision ALU writeback sequencer with 2-entry FIFO
//
// Ports:
//   g_clk     : clock
//   g_resetn  : synchronous active-low reset
//   wb        : scarv_cop_mp_wb_if.slave (ALU beats in, CPR write port out, status out)
// Optional feature macro: SCARV_COP_WB_BYPASS_EN (same-cycle write when FIFO empty and granted).
module scarv_cop_mp_wb (
    input  logic                   g_clk,
    input  logic                   g_resetn,
    scarv_cop_mp_wb_if.slave       wb
);

    typedef struct packed {
        logic        last;
        logic [3:0]  addr;
        logic [3:0]  ben;
        logic [31:0] data;
    } entry_t;

    entry_t      mem [2];
    entry_t      head;
    entry_t      new_entry;
    entry_t      out_entry;
    logic        rptr;
    logic        wptr;
    logic [1:0]  count;
    logic        bcnt;
    logic        bcnt_nxt;
    logic        overflow;
    logic        done;

    logic        beat;
    logic        fifo_valid;
    logic        pop;
    logic        push;
    logic        drop;
    logic        bypass;
    logic        out_valid;

    assign beat       = wb.malu_ivalid && (|wb.malu_cpr_rd_ben);
    assign fifo_valid = (count != 2'd0);
    assign head       = mem[rptr];
    assign pop        = fifo_valid && wb.cpr_wgnt;

`ifdef SCARV_COP_WB_BYPASS_EN
    assign bypass = beat && !fifo_valid && wb.cpr_wgnt;
`else
    assign bypass = 1'b0;
`endif

    // A full FIFO still accepts a beat if the head leaves in the same cycle.
    assign push = beat && !bypass && ((count != 2'd2) || pop);
    assign drop = beat && (count == 2'd2) && !pop;

    // Steer the beat: a lone word with idone goes to id_crd, otherwise the
    // beat counter selects the lo/hi half of the register pair.
    always_comb begin
        new_entry      = '0;
        new_entry.ben  = wb.malu_cpr_rd_ben;
        new_entry.data = wb.malu_cpr_rd_wdata;
        bcnt_nxt       = bcnt;
        if (beat) begin
            if (!bcnt && wb.malu_idone) begin
                new_entry.addr = wb.id_crd;
                new_entry.last = 1'b1;
                bcnt_nxt       = 1'b0;
            end else if (!bcnt) begin
                new_entry.addr = {wb.id_crdm, 1'b0};
                new_entry.last = 1'b0;
                bcnt_nxt       = 1'b1;
            end else begin
                new_entry.addr = {wb.id_crdm, 1'b1};
                new_entry.last = wb.malu_idone;
                bcnt_nxt       = 1'b0;
            end
        end else if (wb.malu_idone) begin
            bcnt_nxt = 1'b0;
        end
    end

    always_ff @(posedge g_clk) begin
        if (push) begin
            mem[wptr] <= new_entry;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            rptr     <= 1'b0;
            wptr     <= 1'b0;
            count    <= 2'd0;
            bcnt     <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (push) begin
                wptr <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            bcnt <= bcnt_nxt;
            if (drop) begin
                overflow <= 1'b1;
            end
            done <= (pop && head.last) || (bypass && new_entry.last);
        end
    end

    // The bypass can only fire with an empty FIFO, so head always wins otherwise.
    assign out_valid = fifo_valid || bypass;
    assign out_entry = fifo_valid ? head : new_entry;

    assign wb.cpr_wen     = out_valid;
    assign wb.cpr_waddr   = out_valid ? out_entry.addr : 4'd0;
    assign wb.cpr_wben    = out_valid ? out_entry.ben  : 4'd0;
    assign wb.cpr_wdata   = out_valid ? out_entry.data : 32'd0;
    assign wb.wb_busy     = fifo_valid || bcnt;
    assign wb.wb_done     = done;
    assign wb.wb_overflow = overflow;

endmodule

// File: tb/tb_scarv_cop_mp_wb.sv
// tb/tb_scarv_cop_mp_wb.sv - directed self-checking bench for scarv_cop_mp_wb
module tb_scarv_cop_mp_wb;

    logic g_clk;
    logic g_resetn;
    int   n_checks;
    int   n_fail;

    scarv_cop_mp_wb_if bus ();

    scarv_cop_mp_wb dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .wb       (bus.slave)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // Inputs change just after a rising edge; outputs are checked on the falling edge.
    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge g_clk);
    endtask

    task automatic drive_beat(input logic [31:0] data, input logic idone);
        bus.malu_ivalid       = 1'b1;
        bus.malu_idone        = idone;
        bus.malu_cpr_rd_ben   = 4'hF;
        bus.malu_cpr_rd_wdata = data;
    endtask

    task automatic drive_idle();
        bus.malu_ivalid       = 1'b0;
        bus.malu_idone        = 1'b0;
        bus.malu_cpr_rd_ben   = 4'h0;
        bus.malu_cpr_rd_wdata = 32'h0;
    endtask

    task automatic test_reset();
        g_resetn = 1'b0;
        drive_idle();
        bus.id_crd   = 4'd5;
        bus.id_crdm  = 3'd3;
        bus.cpr_wgnt = 1'b1;
        step();
        step();
        sample();
        n_checks++;
        if (bus.cpr_wen !== 1'b0) begin
            n_fail++; $display("FAIL reset_wen got %b want 0", bus.cpr_wen);
        end
        n_checks++;
        if ({bus.cpr_waddr, bus.cpr_wben, bus.cpr_wdata} !== 40'd0) begin
            n_fail++; $display("FAIL reset_wport got %h %h %h want 0", bus.cpr_waddr, bus.cpr_wben, bus.cpr_wdata);
        end
        n_checks++;
        if ({bus.wb_busy, bus.wb_done, bus.wb_overflow} !== 3'b000) begin
            n_fail++; $display("FAIL reset_status got %b want 000", {bus.wb_busy, bus.wb_done, bus.wb_overflow});
        end
        step();
        g_resetn = 1'b1;
    endtask

    task automatic test_single();
        bus.id_crd   = 4'd5;
        bus.cpr_wgnt = 1'b1;
        drive_beat(32'h12345678, 1'b1);
        sample();
        n_checks++;
        if (bus.cpr_wen !== 1'b0) begin
            n_fail++; $display("FAIL single_no_comb got %b want 0", bus.cpr_wen);
        end
        step();
        drive_idle();
        sample();
        n_checks++;
        if ({bus.cpr_wen, bus.cpr_waddr, bus.cpr_wben, bus.cpr_wdata} !== {1'b1, 4'd5, 4'hF, 32'h12345678}) begin
            n_fail++; $display("FAIL single_write got %b %h %h %h want 1 5 f 12345678",
                               bus.cpr_wen, bus.cpr_waddr, bus.cpr_wben, bus.cpr_wdata);
        end
        n_checks++;
        if (bus.wb_done !== 1'b0) begin
            n_fail++; $display("FAIL single_done_early got %b want 0", bus.wb_done);
        end
        step();
        sample();
        n_checks++;
        if ({bus.wb_done, bus.cpr_wen, bus.wb_busy} !== 3'b100) begin
            n_fail++; $display("FAIL single_done got done/wen/busy %b want 100", {bus.wb_done, bus.cpr_wen, bus.wb_busy});
        end
        step();
        sample();
        n_checks++;
        if (bus.wb_done !== 1'b0) begin
            n_fail++; $display("FAIL single_done_pulse got %b want 0", bus.wb_done);
        end
    endtask

    task automatic test_pair();
        bus.id_crdm  = 3'd3;
        bus.cpr_wgnt = 1'b1;
        step();
        drive_beat(32'hAAAA0001, 1'b0);
        step();
        drive_beat(32'hBBBB0002, 1'b1);
        sample();
        n_checks++;
        if ({bus.cpr_wen, bus.cpr_waddr, bus.cpr_wdata, bus.wb_busy} !== {1'b1, 4'd6, 32'hAAAA0001, 1'b1}) begin
            n_fail++; $display("FAIL pair_lo got %b %h %h busy %b want 1 6 aaaa0001 1",
                               bus.cpr_wen, bus.cpr_waddr, bus.cpr_wdata, bus.wb_busy);
        end
        step();
        drive_idle();
        sample();
        n_checks++;
        if ({bus.cpr_wen, bus.cpr_waddr, bus.cpr_wdata, bus.wb_done} !== {1'b1, 4'd7, 32'hBBBB0002, 1'b0}) begin
            n_fail++; $display("FAIL pair_hi got %b %h %h done %b want 1 7 bbbb0002 0",
                               bus.cpr_wen, bus.cpr_waddr, bus.cpr_wdata, bus.wb_done);
        end
        step();
        sample();
        n_checks++;
        if ({bus.wb_done, bus.cpr_wen} !== 2'b10) begin
            n_fail++; $display("FAIL pair_done got done/wen %b want 10", {bus.wb_done, bus.cpr_wen});
        end
        step();
        sample();
        n_checks++;
        if ({bus.wb_done, bus.wb_busy} !== 2'b00) begin
            n_fail++; $display("FAIL pair_idle got done/busy %b want 00", {bus.wb_done, bus.wb_busy});
        end
    endtask

    task automatic test_backpressure();
        bus.id_crdm  = 3'd3;
        bus.cpr_wgnt = 1'b0;
        drive_beat(32'hAAAA0001, 1'b0);
        step();
        drive_beat(32'hBBBB0002, 1'b1);
        step();
        drive_idle();
        step();
        step();
        sample();
        n_checks++;
        if ({bus.cpr_wen, bus.cpr_waddr, bus.cpr_wdata, bus.wb_busy} !== {1'b1, 4'd6, 32'hAAAA0001, 1'b1}) begin
            n_fail++; $display("FAIL bp_hold got %b %h %h busy %b want 1 6 aaaa0001 1",
                               bus.cpr_wen, bus.cpr_waddr, bus.cpr_wdata, bus.wb_busy);
        end
        step();
        bus.cpr_wgnt = 1'b1;
        sample();
        n_checks++;
        if ({bus.cpr_wen, bus.cpr_waddr} !== {1'b1, 4'd6}) begin
            n_fail++; $display("FAIL bp_drain_lo got %b %h want 1 6", bus.cpr_wen, bus.cpr_waddr);
        end
        step();
        sample();
        n_checks++;
        if ({bus.cpr_wen, bus.cpr_waddr, bus.cpr_wdata} !== {1'b1, 4'd7, 32'hBBBB0002}) begin
            n_fail++; $display("FAIL bp_drain_hi got %b %h %h want 1 7 bbbb0002", bus.cpr_wen, bus.cpr_waddr, bus.cpr_wdata);
        end
        step();
        sample();
        n_checks++;
        if ({bus.cpr_wen, bus.wb_busy, bus.wb_done, bus.wb_overflow} !== 4'b0010) begin
            n_fail++; $display("FAIL bp_end got wen/busy/done/ovf %b want 0010",
                               {bus.cpr_wen, bus.wb_busy, bus.wb_done, bus.wb_overflow});
        end
        step();
    endtask

    task automatic test_overflow();
        bus.id_crd   = 4'd5;
        bus.id_crdm  = 3'd3;
        bus.cpr_wgnt = 1'b0;
        drive_beat(32'hAAAA0001, 1'b0);
        step();
        drive_beat(32'hBBBB0002, 1'b1);
        step();
        drive_beat(32'hCCCC0003, 1'b1);
        sample();
        n_checks++;
        if (bus.wb_overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_early got %b want 0", bus.wb_overflow);
        end
        step();
        drive_idle();
        sample();
        n_checks++;
        if ({bus.wb_overflow, bus.cpr_wen, bus.cpr_waddr} !== {1'b1, 1'b1, 4'd6}) begin
            n_fail++; $display("FAIL ovf_set got ovf/wen/addr %b %b %h want 1 1 6", bus.wb_overflow, bus.cpr_wen, bus.cpr_waddr);
        end
        step();
        bus.cpr_wgnt = 1'b1;
        sample();
        n_checks++;
        if ({bus.cpr_waddr, bus.cpr_wdata} !== {4'd6, 32'hAAAA0001}) begin
            n_fail++; $display("FAIL ovf_drain0 got %h %h want 6 aaaa0001", bus.cpr_waddr, bus.cpr_wdata);
        end
        step();
        sample();
        n_checks++;
        if ({bus.cpr_waddr, bus.cpr_wdata} !== {4'd7, 32'hBBBB0002}) begin
            n_fail++; $display("FAIL ovf_drain1 got %h %h want 7 bbbb0002", bus.cpr_waddr, bus.cpr_wdata);
        end
        step();
        sample();
        n_checks++;
        if ({bus.cpr_wen, bus.wb_busy, bus.wb_overflow} !== 3'b001) begin
            n_fail++; $display("FAIL ovf_third_dropped got wen/busy/ovf %b want 001", {bus.cpr_wen, bus.wb_busy, bus.wb_overflow});
        end
        step();
        step();
        sample();
        n_checks++;
        if ({bus.cpr_wen, bus.wb_overflow} !== 2'b01) begin
            n_fail++; $display("FAIL ovf_sticky got wen/ovf %b want 01", {bus.cpr_wen, bus.wb_overflow});
        end
    endtask

    task automatic test_reset_mid();
        bus.id_crd   = 4'd9;
        bus.id_crdm  = 3'd3;
        bus.cpr_wgnt = 1'b0;
        drive_beat(32'hAAAA0001, 1'b0);
        step();
        drive_idle();
        g_resetn = 1'b0;
        step();
        g_resetn = 1'b1;
        sample();
        n_checks++;
        if ({bus.cpr_wen, bus.wb_busy, bus.wb_done, bus.wb_overflow} !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_state got wen/busy/done/ovf %b want 0000",
                               {bus.cpr_wen, bus.wb_busy, bus.wb_done, bus.wb_overflow});
        end
        bus.cpr_wgnt = 1'b1;
        step();
        drive_beat(32'h0000BEEF, 1'b1);
        step();
        drive_idle();
        sample();
        n_checks++;
        if ({bus.cpr_wen, bus.cpr_waddr, bus.cpr_wdata} !== {1'b1, 4'd9, 32'h0000BEEF}) begin
            n_fail++; $display("FAIL rstmid_bcnt got %b %h %h want 1 9 0000beef", bus.cpr_wen, bus.cpr_waddr, bus.cpr_wdata);
        end
        step();
        sample();
        n_checks++;
        if (bus.wb_done !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_done got %b want 1", bus.wb_done);
        end
        step();
    endtask

    task automatic test_compare();
        bus.id_crd   = 4'd11;
        bus.id_crdm  = 3'd2;
        bus.cpr_wgnt = 1'b1;
        // A lone compare-style completion: idone with no byte enables.
        bus.malu_ivalid     = 1'b1;
        bus.malu_idone      = 1'b1;
        bus.malu_cpr_rd_ben = 4'h0;
        step();
        drive_idle();
        sample();
        n_checks++;
        if ({bus.cpr_wen, bus.wb_busy, bus.wb_done} !== 3'b000) begin
            n_fail++; $display("FAIL cmp_nowrite got wen/busy/done %b want 000", {bus.cpr_wen, bus.wb_busy, bus.wb_done});
        end
        step();
        sample();
        n_checks++;
        if (bus.wb_done !== 1'b0) begin
            n_fail++; $display("FAIL cmp_nodone got %b want 0", bus.wb_done);
        end
        // Partial pair abandoned by an idone without a beat must clear bcnt.
        drive_beat(32'h11110000, 1'b0);
        step();
        bus.malu_ivalid     = 1'b1;
        bus.malu_idone      = 1'b1;
        bus.malu_cpr_rd_ben = 4'h0;
        sample();
        n_checks++;
        if ({bus.cpr_wen, bus.cpr_waddr, bus.wb_busy} !== {1'b1, 4'd4, 1'b1}) begin
            n_fail++; $display("FAIL cmp_lo got %b %h busy %b want 1 4 1", bus.cpr_wen, bus.cpr_waddr, bus.wb_busy);
        end
        step();
        drive_beat(32'h22220000, 1'b1);
        sample();
        n_checks++;
        if ({bus.wb_done, bus.wb_busy} !== 2'b00) begin
            n_fail++; $display("FAIL cmp_abandon got done/busy %b want 00", {bus.wb_done, bus.wb_busy});
        end
        step();
        drive_idle();
        sample();
        n_checks++;
        if ({bus.cpr_wen, bus.cpr_waddr, bus.cpr_wdata} !== {1'b1, 4'd11, 32'h22220000}) begin
            n_fail++; $display("FAIL cmp_next_single got %b %h %h want 1 b 22220000", bus.cpr_wen, bus.cpr_waddr, bus.cpr_wdata);
        end
        step();
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_pair();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_compare();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
